fifo_write_arbiter: RTL

- Round-robin arbiter sharing the write port of async_fifo among NUM_REQ requesters in the write clock domain.
- Grants one requester at a time for a locked burst, ended by a last flag or MAX_BURST beats.
- Gates the FIFO write with its full and almost_full flags.
- Drives the FIFO's write_en and write_data directly.

---
 rtl/fifo_arb_pkg.sv | 25 ++
 rtl/rr_priority_picker.sv | 39 +++
 rtl/fifo_write_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEFAULT_NUM_REQ   = 4;
    localparam int DEFAULT_MAX_BURST = 4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, modulo NUM_REQ.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEFAULT_NUM_REQ,
    parameter int ID_WIDTH = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] rr_ptr_i,
    output logic                any_req_o,
    output logic [ID_WIDTH-1:0] winner_o
);

    localparam logic [ID_WIDTH:0] NREQ_W = (ID_WIDTH + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0]  rotated;
    logic [ID_WIDTH-1:0] offset;
    logic [ID_WIDTH:0]   sum;

    assign any_req_o = |req_i;

    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        // Rotating the doubled vector puts rr_ptr_i at bit 0.
        rotated = NUM_REQ'({req_i, req_i} >> rr_ptr_i);
        offset  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = ID_WIDTH'(i);
            end
        end
        sum = {1'b0, rr_ptr_i} + {1'b0, offset};
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        winner_o = sum[ID_WIDTH-1:0];
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter granting locked bursts on the async FIFO write port.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST,
    parameter int ID_WIDTH   = clog2(NUM_REQ)
) (
    input  logic                          write_clk,
    input  logic                          write_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    localparam int                  CNT_W     = clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0]    LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

    arb_state_e          state_q, state_d;
    logic [ID_WIDTH-1:0] owner_q, owner_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic                any_req;
    logic [ID_WIDTH-1:0] winner;
    logic                xfer;
    logic                term_beat;

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .req_i     (req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .any_req_o (any_req),
        .winner_o  (winner)
    );

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_ptr_d        = rr_ptr_q;
        beat_cnt_d      = beat_cnt_q;
        busy            = 1'b0;
        req_ready       = '0;
        xfer            = 1'b0;
        term_beat       = 1'b0;
        fifo_write_data = '0;
        case (state_q)
            IDLE: begin
                // almost_full only holds off new grants, never an active burst.
                if (any_req && !fifo_almost_full) begin
                    owner_d    = winner;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                busy               = 1'b1;
                req_ready[owner_q] = !fifo_full;
                xfer               = req_valid[owner_q] && !fifo_full;
                fifo_write_data    = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
                term_beat          = xfer && (req_last[owner_q] || (beat_cnt_q == LAST_BEAT));
                if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                if (term_beat) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_write_en = xfer;
    assign grant_id      = owner_q;

    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of block order.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
